// File: rtl/check_result_uart_tx.sv
// check_result_uart_tx: on-chip pass/fail bookkeeping for self-test compare strobes.
// It keeps saturating pass/fail counters and the first failing expected/actual pair.
// On request it sends a 6-byte summary frame (HDR, PASS hi/lo, FAIL hi/lo, LF) over UART 8N1.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_clear                   synchronous clear of counters and first-fail capture
//   i_chk_valid               one compare this cycle of i_chk_expected vs i_chk_actual
//   i_report_req              start a summary frame (ignored while o_report_busy)
//   o_report_busy             frame in progress
//   o_pass_count/o_fail_count live saturating counts
//   o_first_fail_*            first captured failure since reset/clear
//   o_uart_tx                 serial output, idles high
module check_result_uart_tx #(
  parameter int unsigned WAIT            = 8,
  parameter bit          CLEAR_ON_REPORT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_chk_valid,
  input  logic [31:0] i_chk_expected,
  input  logic [31:0] i_chk_actual,
  input  logic        i_report_req,
  output logic        o_report_busy,
  output logic [15:0] o_pass_count,
  output logic [15:0] o_fail_count,
  output logic        o_first_fail_valid,
  output logic [31:0] o_first_fail_expected,
  output logic [31:0] o_first_fail_actual,
  output logic        o_uart_tx
);

  localparam int unsigned CntW = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_bit_idx, w_bit_idx_d;
  logic [2:0]      r_byte_idx, w_byte_idx_d;
  logic [15:0]     r_pass, w_pass_d, r_fail, w_fail_d;
  logic [15:0]     r_snap_pass, w_snap_pass_d, r_snap_fail, w_snap_fail_d;
  logic            r_ffv, w_ffv_d;
  logic [31:0]     r_ffe, w_ffe_d, r_ffa, w_ffa_d;
  logic            r_tx, w_tx_d;
  logic            w_accept, w_clr, w_bit_end;
  logic [7:0]      w_byte;

  assign w_accept  = i_report_req && (r_state == StIdle);
  assign w_bit_end = (r_cnt == CntW'(WAIT - 1));

  // Live counters: clear is applied first so a same-cycle compare lands in the cleared regs.
  always_comb begin
    w_clr    = i_clear || (CLEAR_ON_REPORT && w_accept);
    w_pass_d = w_clr ? 16'd0 : r_pass;
    w_fail_d = w_clr ? 16'd0 : r_fail;
    w_ffv_d  = w_clr ? 1'b0 : r_ffv;
    w_ffe_d  = w_clr ? 32'd0 : r_ffe;
    w_ffa_d  = w_clr ? 32'd0 : r_ffa;
    if (i_chk_valid) begin
      if (i_chk_expected == i_chk_actual) begin
        if (w_pass_d != 16'hFFFF) w_pass_d = w_pass_d + 16'd1;
      end else begin
        if (w_fail_d != 16'hFFFF) w_fail_d = w_fail_d + 16'd1;
        if (!w_ffv_d) begin
          w_ffv_d = 1'b1;
          w_ffe_d = i_chk_expected;
          w_ffa_d = i_chk_actual;
        end
      end
    end
    // Snapshot uses pre-edge values so the frame reflects counts before this cycle's compare.
    w_snap_pass_d = w_accept ? r_pass : r_snap_pass;
    w_snap_fail_d = w_accept ? r_fail : r_snap_fail;
  end

  // Transmit sequencer: one START/DATA/STOP pass per byte, six bytes per frame.
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt + CntW'(1);
    w_bit_idx_d  = r_bit_idx;
    w_byte_idx_d = r_byte_idx;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_accept) begin
          w_state_d    = StStart;
          w_bit_idx_d  = 3'd0;
          w_byte_idx_d = 3'd0;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_cnt_d     = '0;
          w_state_d   = StData;
          w_bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_d = '0;
          if (r_bit_idx == 3'd7) w_state_d = StStop;
          else w_bit_idx_d = r_bit_idx + 3'd1;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_cnt_d = '0;
          if (r_byte_idx < 3'd5) begin
            w_state_d    = StStart;
            w_byte_idx_d = r_byte_idx + 3'd1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level is computed from next-state values and registered so o_uart_tx is glitch-free.
  always_comb begin
    case (w_byte_idx_d)
      3'd0:    w_byte = (w_snap_fail_d == 16'd0) ? 8'h4F : 8'h58;
      3'd1:    w_byte = w_snap_pass_d[15:8];
      3'd2:    w_byte = w_snap_pass_d[7:0];
      3'd3:    w_byte = w_snap_fail_d[15:8];
      3'd4:    w_byte = w_snap_fail_d[7:0];
      default: w_byte = 8'h0A;
    endcase
    case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_byte[w_bit_idx_d];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 3'd0;
      r_pass      <= 16'd0;
      r_fail      <= 16'd0;
      r_snap_pass <= 16'd0;
      r_snap_fail <= 16'd0;
      r_ffv       <= 1'b0;
      r_ffe       <= 32'd0;
      r_ffa       <= 32'd0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_byte_idx  <= w_byte_idx_d;
      r_pass      <= w_pass_d;
      r_fail      <= w_fail_d;
      r_snap_pass <= w_snap_pass_d;
      r_snap_fail <= w_snap_fail_d;
      r_ffv       <= w_ffv_d;
      r_ffe       <= w_ffe_d;
      r_ffa       <= w_ffa_d;
      r_tx        <= w_tx_d;
    end
  end

  assign o_report_busy         = (r_state != StIdle);
  assign o_pass_count          = r_pass;
  assign o_fail_count          = r_fail;
  assign o_first_fail_valid    = r_ffv;
  assign o_first_fail_expected = r_ffe;
  assign o_first_fail_actual   = r_ffa;
  assign o_uart_tx             = r_tx;

endmodule
